// File: rtl/skeleton_writeback_if.sv
// -----------------------------------------------------------------------------
// skeleton_writeback_if
// Bundles the pass-result stream coming from the upstream convolution unit,
// the reload stream going back to it, and the status/counter outputs of the
// writeback block.
//
// Stream semantics: write_out_enable qualifies primary_address,
// primary_output and harrisBit in the same cycle. There is no back-pressure.
// Upstream holds each address for two cycles. The consumer takes a sample
// only on the first cycle of each address. On the reload side, reload_we
// qualifies reload_data, and reload_data is forced to zero while reload_we
// is low.
//
// Signals (direction as seen from the writeback block, modport slave):
//   write_out_enable  in   upstream is streaming a pass result
//   primary_address   in   pixel index of the current sample
//   primary_output    in   thinned pixel value for primary_address
//   harrisBit         in   corner flag for the current sample
//   reload_we         out  upstream write enable during frame re-stream
//   reload_data       out  upstream data during frame re-stream
//   done              out  processing finished, held until reset
//   converged         out  1 = last pass changed nothing, 0 = pass limit hit
//   iter_count        out  completed passes
//   change_count      out  changed pixels in the current/last pass
//   corner_count      out  corner-flagged samples in the current/last pass
//   dbg_state         out  FSM state (IDLE=0 CAPTURE=1 DECIDE=2 RELOAD=3 DONE=4)
// -----------------------------------------------------------------------------
interface skeleton_writeback_if #(
   parameter int bitSize    = 6,
   parameter int pixelWidth = 8
);
   logic                  write_out_enable;
   logic [bitSize:0]      primary_address;
   logic [pixelWidth-1:0] primary_output;
   logic                  harrisBit;
   logic                  reload_we;
   logic [pixelWidth-1:0] reload_data;
   logic                  done;
   logic                  converged;
   logic [7:0]            iter_count;
   logic [bitSize+1:0]    change_count;
   logic [bitSize+1:0]    corner_count;
   logic [2:0]            dbg_state;

   modport master (
      output write_out_enable, primary_address, primary_output, harrisBit,
      input  reload_we, reload_data, done, converged, iter_count,
             change_count, corner_count, dbg_state
   );

   modport slave (
      input  write_out_enable, primary_address, primary_output, harrisBit,
      output reload_we, reload_data, done, converged, iter_count,
             change_count, corner_count, dbg_state
   );
endinterface

// File: rtl/skeleton_writeback.sv
// -----------------------------------------------------------------------------
// skeleton_writeback
// This block captures one thinning pass streamed out of the convolution unit
// into a local frame buffer. While it does so, it counts the pixels that
// differ from the previous pass and the samples that carry a corner flag.
// At the end of the pass it decides whether to stop. The block stops when
// the frame has converged or when MAX_ITER passes have run. Otherwise it
// re-streams the buffered frame to the upstream unit so that the next pass
// can start.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-high reset (frame buffer is not cleared)
//   bus   skeleton_writeback_if.slave: the input stream, the reload stream,
//         and the status/counters (see the interface header)
// -----------------------------------------------------------------------------
module skeleton_writeback #(
   parameter int N          = 8,
   parameter int bitSize    = 6,
   parameter int pixelWidth = 8,
   parameter int MAX_ITER   = 16
) (
   input logic                 clk,
   input logic                 rst,
   skeleton_writeback_if.slave bus
);
   localparam int unsigned PIXELS = N * N;
   localparam int          IW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int          CW     = IW + 1;      // reload cycle counter, 2*N*N cycles
   localparam int          AW     = bitSize + 1;
   localparam int          KW     = bitSize + 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_DECIDE  = 3'd2,
      S_RELOAD  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  prev_we_q, prev_we_d;
   logic [AW-1:0]         last_addr_q, last_addr_d;
   logic [7:0]            iter_q, iter_d;
   logic [KW-1:0]         change_q, change_d;
   logic [KW-1:0]         corner_q, corner_d;
   logic                  converged_q, converged_d;
   logic [CW-1:0]         rl_cnt_q, rl_cnt_d;

   logic [pixelWidth-1:0] frame_mem [PIXELS];

   logic                  accepting;
   logic                  take;
   logic                  in_range;
   logic                  wr_en;
   logic [IW-1:0]         wr_idx;
   logic [IW-1:0]         rd_idx;
   logic [pixelWidth-1:0] old_pix;
   logic                  reload_active;

   // The block accepts stream input only while it waits for a pass or
   // captures one. The input is ignored in DECIDE, RELOAD and DONE.
   assign accepting = (state_q == S_IDLE) || (state_q == S_CAPTURE);

   // Upstream holds each address for two cycles. The block takes a sample
   // on the rising edge of the enable or when the address moves on.
   assign take = accepting && bus.write_out_enable &&
                 (!prev_we_q || (bus.primary_address != last_addr_q));

   assign in_range = 32'(bus.primary_address) < PIXELS;
   assign wr_en    = take && in_range;
   assign wr_idx   = bus.primary_address[IW-1:0];
   assign old_pix  = frame_mem[wr_idx];

   // Each buffered pixel is presented for two reload cycles.
   assign rd_idx   = IW'(rl_cnt_q >> 1);

   always_comb begin
      state_d     = state_q;
      prev_we_d   = 1'b0;
      last_addr_d = last_addr_q;
      iter_d      = iter_q;
      change_d    = change_q;
      corner_d    = corner_q;
      converged_d = converged_q;
      rl_cnt_d    = rl_cnt_q;

      // Outside the accepting states the enable history is cleared, so the
      // first sample of the next pass is always recognised as new.
      if (accepting) prev_we_d = bus.write_out_enable;
      if (take)      last_addr_d = bus.primary_address;

      case (state_q)
         S_IDLE: begin
            if (bus.write_out_enable) begin
               state_d  = S_CAPTURE;
               change_d = '0;
               corner_d = '0;
            end
         end
         S_CAPTURE: begin
            if (!bus.write_out_enable) state_d = S_DECIDE;
         end
         S_DECIDE: begin
            iter_d = iter_q + 8'd1;
            // The first pass has no previous frame to compare against, so
            // it can never count as converged.
            if ((iter_q != 8'd0) && (change_q == '0)) begin
               state_d     = S_DONE;
               converged_d = 1'b1;
            end else if (iter_q == 8'(MAX_ITER - 1)) begin
               state_d     = S_DONE;
               converged_d = 1'b0;
            end else begin
               state_d  = S_RELOAD;
               rl_cnt_d = '0;
            end
         end
         S_RELOAD: begin
            rl_cnt_d = rl_cnt_q + 1'b1;
            if (rl_cnt_q == CW'(2 * PIXELS - 1)) state_d = S_IDLE;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The counters build on the values chosen above, so the first sample
      // of a pass counts on top of the cleared values.
      if (wr_en) begin
         if (bus.primary_output != old_pix) change_d = change_d + 1'b1;
         if (bus.harrisBit)                 corner_d = corner_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         prev_we_q   <= 1'b0;
         last_addr_q <= '0;
         iter_q      <= '0;
         change_q    <= '0;
         corner_q    <= '0;
         converged_q <= 1'b0;
         rl_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         prev_we_q   <= prev_we_d;
         last_addr_q <= last_addr_d;
         iter_q      <= iter_d;
         change_q    <= change_d;
         corner_q    <= corner_d;
         converged_q <= converged_d;
         rl_cnt_q    <= rl_cnt_d;
      end
   end

   // The frame buffer keeps its contents through reset. Reset still blocks
   // a write that falls in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) frame_mem[wr_idx] <= bus.primary_output;
   end

   assign reload_active    = (state_q == S_RELOAD);
   assign bus.reload_we    = reload_active;
   assign bus.reload_data  = reload_active ? frame_mem[rd_idx] : '0;
   assign bus.done         = (state_q == S_DONE);
   assign bus.converged    = converged_q;
   assign bus.iter_count   = iter_q;
   assign bus.change_count = change_q;
   assign bus.corner_count = corner_q;
   assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_skeleton_writeback.sv
module tb_skeleton_writeback;
   localparam int N      = 8;
   localparam int BS     = 6;
   localparam int PW     = 8;
   localparam int MAXI   = 4;
   localparam int PIX    = N * N;
   localparam int RL_LEN = 2 * PIX;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DECIDE  = 3'd2;
   localparam logic [2:0] ST_RELOAD  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   skeleton_writeback_if #(.bitSize(BS), .pixelWidth(PW)) bus ();

   skeleton_writeback #(.N(N), .bitSize(BS), .pixelWidth(PW), .MAX_ITER(MAXI)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] model_buf [PIX];
   logic [PW-1:0] pass_val  [PIX];
   logic          pass_h    [PIX];
   int            pass_hold [PIX];
   int            oor_after  = -1;
   int            exp_change = 0;
   int            exp_corner = 0;
   int            exp_iter   = 0;

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.write_out_enable = 1'b0;
      bus.primary_address  = '0;
      bus.primary_output   = '0;
      bus.harrisBit        = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_iter = 0;
      exp_q.delete();
   endtask

   // Streams pass_val/pass_h with per-address hold counts, updates the model
   // and queues the reload data the DUT should produce afterwards.
   task automatic stream_pass();
      exp_change = 0;
      exp_corner = 0;
      for (int a = 0; a < PIX; a++) begin
         if (model_buf[a] !== pass_val[a]) exp_change++;
         if (pass_h[a]) exp_corner++;
         model_buf[a] = pass_val[a];
         for (int r = 0; r < pass_hold[a]; r++) begin
            @(negedge clk);
            bus.write_out_enable = 1'b1;
            bus.primary_address  = 7'(a);
            bus.primary_output   = pass_val[a];
            bus.harrisBit        = pass_h[a];
         end
         if (a == oor_after) begin
            for (int r = 0; r < 2; r++) begin
               @(negedge clk);
               bus.primary_address = 7'(PIX);
               bus.primary_output  = 8'h5A;
               bus.harrisBit       = 1'b1;
            end
         end
      end
      @(negedge clk);
      drive_idle();
      for (int k = 0; k < RL_LEN; k++) exp_q.push_back(model_buf[k >> 1]);
   endtask

   task automatic set_default_holds();
      for (int a = 0; a < PIX; a++) pass_hold[a] = 2;
      oor_after = -1;
   endtask

   // Checks the DECIDE cycle and the state that follows it.
   task automatic check_pass(input logic [2:0] want_state, input logic want_conv,
                             input bit chk_change, input string tag);
      @(negedge clk);
      n_vec++;
      if (bus.dbg_state !== ST_DECIDE) begin
         n_err++; $display("FAIL %s decide_state: got %0d expected %0d", tag, bus.dbg_state, ST_DECIDE);
      end
      n_vec++;
      if (bus.corner_count !== 8'(exp_corner)) begin
         n_err++; $display("FAIL %s corner_count: got %0d expected %0d", tag, bus.corner_count, exp_corner);
      end
      if (chk_change) begin
         n_vec++;
         if (bus.change_count !== 8'(exp_change)) begin
            n_err++; $display("FAIL %s change_count: got %0d expected %0d", tag, bus.change_count, exp_change);
         end
      end
      exp_iter++;
      @(negedge clk);
      n_vec++;
      if (bus.iter_count !== 8'(exp_iter)) begin
         n_err++; $display("FAIL %s iter_count: got %0d expected %0d", tag, bus.iter_count, exp_iter);
      end
      n_vec++;
      if (bus.dbg_state !== want_state) begin
         n_err++; $display("FAIL %s next_state: got %0d expected %0d", tag, bus.dbg_state, want_state);
      end
      n_vec++;
      if (bus.done !== (want_state == ST_DONE)) begin
         n_err++; $display("FAIL %s done: got %0b expected %0b", tag, bus.done, want_state == ST_DONE);
      end
      if (want_state == ST_DONE) begin
         n_vec++;
         if (bus.converged !== want_conv) begin
            n_err++; $display("FAIL %s converged: got %0b expected %0b", tag, bus.converged, want_conv);
         end
         exp_q.delete();
      end
   endtask

   // Consumes the reload stream against exp_q. Optionally asserts reset at
   // reload cycle rst_at, or pulses write_out_enable starting at pulse_at.
   task automatic run_reload(input int rst_at, input int pulse_at, input string tag);
      int n;
      int guard;
      logic [PW-1:0] want;
      n = 0;
      guard = 0;
      while (bus.reload_we === 1'b1 && guard < 400) begin
         guard++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++; $display("FAIL %s reload_extra: got data %0h at cycle %0d expected none", tag, bus.reload_data, n);
         end else begin
            want = exp_q.pop_front();
            if (bus.reload_data !== want) begin
               n_err++; $display("FAIL %s reload_data[%0d]: got %0h expected %0h", tag, n, bus.reload_data, want);
            end
         end
         if (n == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            n_vec++;
            if (bus.reload_we !== 1'b0 || bus.reload_data !== '0) begin
               n_err++; $display("FAIL %s rst_reload: got we=%0b data=%0h expected we=0 data=0", tag, bus.reload_we, bus.reload_data);
            end
            n_vec++;
            if (bus.dbg_state !== ST_IDLE || bus.done !== 1'b0 || bus.converged !== 1'b0) begin
               n_err++; $display("FAIL %s rst_state: got state=%0d done=%0b conv=%0b expected 0 0 0", tag, bus.dbg_state, bus.done, bus.converged);
            end
            n_vec++;
            if (bus.iter_count !== 8'd0 || bus.change_count !== 8'd0 || bus.corner_count !== 8'd0) begin
               n_err++; $display("FAIL %s rst_counters: got %0d/%0d/%0d expected 0/0/0", tag, bus.iter_count, bus.change_count, bus.corner_count);
            end
            exp_q.delete();
            exp_iter = 0;
            return;
         end
         if (n == pulse_at) begin
            bus.write_out_enable = 1'b1;
            bus.primary_address  = 7'(PIX - 1);
            bus.primary_output   = ~model_buf[PIX-1];
            bus.harrisBit        = 1'b1;
         end
         if (n == pulse_at + 2) drive_idle();
         n++;
         @(negedge clk);
      end
      n_vec++;
      if (n != RL_LEN) begin
         n_err++; $display("FAIL %s reload_len: got %0d expected %0d", tag, n, RL_LEN);
      end
      n_vec++;
      if (bus.reload_data !== '0 || bus.dbg_state !== ST_IDLE) begin
         n_err++; $display("FAIL %s after_reload: got data=%0h state=%0d expected 0 %0d", tag, bus.reload_data, bus.dbg_state, ST_IDLE);
      end
      n_vec++;
      if (bus.change_count !== 8'(exp_change) || bus.corner_count !== 8'(exp_corner) || bus.iter_count !== 8'(exp_iter)) begin
         n_err++; $display("FAIL %s held_counters: got %0d/%0d/%0d expected %0d/%0d/%0d", tag,
                           bus.change_count, bus.corner_count, bus.iter_count, exp_change, exp_corner, exp_iter);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL %s reload_short: got %0d left expected 0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_vec++;
      if (bus.dbg_state !== ST_IDLE || bus.done !== 1'b0 || bus.converged !== 1'b0) begin
         n_err++; $display("FAIL reset_state: got state=%0d done=%0b conv=%0b expected 0 0 0", bus.dbg_state, bus.done, bus.converged);
      end
      n_vec++;
      if (bus.reload_we !== 1'b0 || bus.reload_data !== '0) begin
         n_err++; $display("FAIL reset_reload: got we=%0b data=%0h expected 0 0", bus.reload_we, bus.reload_data);
      end
      n_vec++;
      if (bus.iter_count !== 8'd0 || bus.change_count !== 8'd0 || bus.corner_count !== 8'd0) begin
         n_err++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", bus.iter_count, bus.change_count, bus.corner_count);
      end
   endtask

   task automatic test_first_pass();
      set_default_holds();
      for (int a = 0; a < PIX; a++) begin
         pass_val[a] = 8'hFF;
         pass_h[a]   = (a == 3) || (a == 17) || (a == 40);
      end
      stream_pass();
      check_pass(ST_RELOAD, 1'b0, 1'b0, "first_pass");
      run_reload(-1, -1, "first_reload");
   endtask

   task automatic test_converge();
      set_default_holds();
      stream_pass();
      check_pass(ST_DONE, 1'b1, 1'b1, "converge");
      // DONE ignores the stream and holds everything still.
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            bus.write_out_enable = 1'b1;
            bus.primary_address  = 7'(5 + c);
            bus.primary_output   = ~model_buf[5 + c];
            bus.harrisBit        = 1'b1;
         end else begin
            drive_idle();
         end
         @(negedge clk);
         n_vec++;
         if (bus.dbg_state !== ST_DONE || bus.reload_we !== 1'b0 || bus.done !== 1'b1 || bus.converged !== 1'b1 ||
             bus.iter_count !== 8'd2 || bus.change_count !== 8'd0 || bus.corner_count !== 8'd3) begin
            n_err++; $display("FAIL done_hold[%0d]: got st=%0d we=%0b done=%0b conv=%0b it=%0d ch=%0d co=%0d expected 4 0 1 1 2 0 3",
                              c, bus.dbg_state, bus.reload_we, bus.done, bus.converged, bus.iter_count, bus.change_count, bus.corner_count);
         end
      end
   endtask

   task automatic test_boundary_and_reset();
      do_reset();
      set_default_holds();
      pass_hold[10] = 4;
      pass_hold[20] = 6;
      oor_after     = 30;
      for (int a = 0; a < PIX; a++) begin
         pass_val[a] = 8'($urandom_range(0, 255));
         pass_h[a]   = 1'($urandom_range(0, 1));
      end
      pass_val[0]  = ~model_buf[0];
      pass_val[63] = model_buf[63];
      stream_pass();
      check_pass(ST_RELOAD, 1'b0, 1'b1, "boundary");
      run_reload(50, -1, "reset_mid_reload");
   endtask

   task automatic test_first_after_reset();
      set_default_holds();
      for (int a = 0; a < PIX; a++) pass_val[a] = model_buf[a];
      stream_pass();
      check_pass(ST_RELOAD, 1'b0, 1'b1, "no_first_converge");
      run_reload(-1, 100, "reload_pulse");
   endtask

   task automatic test_max_iter();
      int flip [3];
      flip[0] = 7;
      flip[1] = 33;
      flip[2] = 60;
      set_default_holds();
      for (int p = 0; p < 3; p++) begin
         for (int a = 0; a < PIX; a++) pass_val[a] = model_buf[a];
         pass_val[flip[p]] = ~model_buf[flip[p]];
         stream_pass();
         if (p < 2) begin
            check_pass(ST_RELOAD, 1'b0, 1'b1, "iter_pass");
            run_reload(-1, -1, "iter_reload");
         end else begin
            check_pass(ST_DONE, 1'b0, 1'b1, "max_iter");
         end
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_first_pass();
      test_converge();
      test_boundary_and_reset();
      test_first_after_reset();
      test_max_iter();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/skeleton_writeback.md
SKELETON_WRITEBACK -- requirements
Module: skeleton_writeback

Interface
REQ-001 Parameter N, default 8, image side length in pixels; frame is N*N pixels.
REQ-002 Parameter bitSize, default 6, address MSB index; addresses are bitSize+1 bits wide.
REQ-003 Parameter pixelWidth, default 8, pixel width in bits.
REQ-004 Parameter MAX_ITER, default 16, maximum thinning passes before forced stop.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 write_out_enable  in  1  upstream convolution unit is streaming a pass result.
REQ-008 primary_address  in  bitSize+1  pixel index of current result sample.
REQ-009 primary_output  in  pixelWidth  thinned pixel value for primary_address.
REQ-010 harrisBit  in  1  corner flag accompanying current sample.
REQ-011 reload_we  out  1  drives upstream we while the frame is re-streamed for the next pass.
REQ-012 reload_data  out  pixelWidth  drives upstream data_in during reload.
REQ-013 done  out  1  processing finished; held until rst.
REQ-014 converged  out  1  valid when done=1; 1 = no pixel changed in final pass, 0 = MAX_ITER stop.
REQ-015 iter_count  out  8  completed passes.
REQ-016 change_count  out  bitSize+2  pixels changed in current/last pass.
REQ-017 corner_count  out  bitSize+2  samples with harrisBit=1 in current/last pass.

Function
REQ-018 Block SHALL hold an internal N*N x pixelWidth frame buffer (not reset).
REQ-019 FSM states SHALL be IDLE, CAPTURE, DECIDE, RELOAD, DONE.
REQ-020 IDLE: write_out_enable=1 -> CAPTURE; change_count and corner_count cleared on that edge; first sample taken that same cycle.
REQ-021 Sample SHALL be taken when write_out_enable=1 and (previous-cycle write_out_enable=0 or primary_address != last sampled address); each address is taken once despite upstream's two-cycle cadence.
REQ-022 Samples with primary_address >= N*N SHALL be ignored (no write, no count).
REQ-023 Per sample: if primary_output != buffer[addr] then change_count+1; if harrisBit=1 then corner_count+1; buffer[addr] <= primary_output; all visible next edge.
REQ-024 CAPTURE: write_out_enable=0 -> DECIDE.
REQ-025 DECIDE (1 cycle): iter_count+1; if old iter_count!=0 and change_count=0 -> DONE, converged=1; else if new iter_count=MAX_ITER -> DONE, converged=0; else -> RELOAD.
REQ-026 First pass after reset SHALL never be judged converged.
REQ-027 RELOAD: 2*N*N cycles, reload_we=1, reload_data=buffer[k>>1] for cycle k=0..2N*N-1 (each pixel held two cycles); then -> IDLE with reload_we=0.
REQ-028 reload_data SHALL be 0 whenever reload_we=0.
REQ-029 write_out_enable in DECIDE, RELOAD, DONE SHALL be ignored.
REQ-030 DONE: done=1, all counters frozen, outputs stable until rst.
REQ-031 Counters SHALL not saturate; bitSize+2 bits cover N*N samples.

Reset
REQ-032 rst=1 at any edge, including mid-CAPTURE or mid-RELOAD, SHALL force IDLE; reload_we=0, reload_data=0, done=0, converged=0, iter_count=0, change_count=0, corner_count=0; buffer contents unchanged.
REQ-033 rst SHALL dominate all other inputs in the same cycle.

Verification
REQ-034 N=8: reset, stream 64 addresses each held 2 cycles, values 0xFF, harrisBit=1 on 3 -> after fall: corner_count=3, iter_count=1, RELOAD with reload_we high exactly 128 cycles, reload_data=0xFF.
REQ-035 Second pass identical to first -> change_count=0, done=1, converged=1, iter_count=2, no RELOAD.
REQ-036 Every pass changes one pixel, MAX_ITER=4 -> done=1, converged=0, iter_count=4 after fourth pass.
REQ-037 Address 64 and repeated same address inside a pass -> ignored / counted once; change_count matches distinct in-range differing pixels.
REQ-038 rst asserted at RELOAD cycle 50 -> next cycle reload_we=0, state IDLE, counters 0; new pass then captured normally.
REQ-039 write_out_enable pulsed during RELOAD -> no buffer write, counters unchanged, RELOAD length still 128.
